// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Shared constants and types for the PWM output driver.
//   NUM_CH    : number of output channels (two 8-bit enable registers)
//   CNT_W     : width of the PWM period counter
//   DUTY_FULL : duty code that means "always high"
//   pwm_state_t / ST_IDLE / ST_RUN : FSM encoding (the top keeps its state
//   register as plain logic [0:0] and compares against the localparams).
//   stagger_offset(): phase offset added to the counter for channel ch when
//   the staggered-edge build (PWM_STAGGER_EN) is selected.
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int NUM_CH = 16;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  // Each channel is shifted by 16 counts so the 16 channels cover the whole
  // 256-count period evenly; the sum wraps mod 256.
  function automatic logic [CNT_W-1:0] stagger_offset(input int unsigned ch);
    return CNT_W'(ch * 16);
  endfunction

endpackage

// File: rtl/pwm_output_driver_prescaler.sv
// ---------------------------------------------------------------------------
// pwm_prescaler
//   Divides clk down to the PWM count rate. While run is high the internal
//   counter walks 0..CLK_DIV-1 and tick is high on the cycle it sits at
//   CLK_DIV-1, after which it wraps to 0. While run is low the counter is
//   held at 0 so the first tick after run rises comes CLK_DIV cycles later.
//   With CLK_DIV=1 tick simply follows run.
// Ports
//   clk   in  1  system clock
//   rst_n in  1  asynchronous, active-low reset
//   run   in  1  count enable; low clears the divider
//   tick  out 1  one-cycle count strobe
// ---------------------------------------------------------------------------
module pwm_prescaler #(
  parameter int CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

  logic [PS_W-1:0] r_ps;
  logic            w_at_last;

  assign w_at_last = (r_ps == PS_LAST);
  assign tick      = run && w_at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ps <= '0;
    end else if (!run || w_at_last) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + PS_W'(1);
    end
  end

endmodule

// File: rtl/pwm_output_driver.sv
// ---------------------------------------------------------------------------
// pwm_output_driver
//   Takes the five configuration registers from the SPI register file and
//   drives 16 registered output pins. Each pin is forced low (en_out=0),
//   forced high (en_out=1, en_pwm=0) or follows a shared 8-bit PWM waveform
//   (en_out=1, en_pwm=1). Duty changes are captured into a shadow register
//   only at period boundaries, so a running period is never cut short.
//
//   FSM: IDLE while no channel selects PWM (counters held at 0), RUN while
//   at least one does. Entering RUN restarts the counters, loads the duty
//   shadow and pulses period_start; leaving RUN clears the counters and
//   issues no pulse.
//
// Build option
//   PWM_STAGGER_EN : when defined, channel i compares (cnt + 16*i) mod 256
//                    against the duty so channel edges are spread over the
//                    period; when undefined every channel uses cnt directly.
//
// Ports
//   clk              in   1   system clock
//   rst_n            in   1   asynchronous, active-low reset
//   en_reg_out_7_0   in   8   output enable, channels 7..0
//   en_reg_out_15_8  in   8   output enable, channels 15..8
//   en_reg_pwm_7_0   in   8   PWM mode select, channels 7..0
//   en_reg_pwm_15_8  in   8   PWM mode select, channels 15..8
//   pwm_duty_cycle   in   8   requested duty, 0x00 = 0 %, 0xFF = 100 %
//   out              out  16  registered channel outputs
//   period_start     out  1   pulse during the first cycle of each period
//   o_dbg_state      out  1   current FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
module pwm_output_driver
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       en_reg_out_7_0,
  input  logic [7:0]       en_reg_out_15_8,
  input  logic [7:0]       en_reg_pwm_7_0,
  input  logic [7:0]       en_reg_pwm_15_8,
  input  logic [7:0]       pwm_duty_cycle,
  output logic [15:0]      out,
  output logic             period_start,
  output logic [0:0]       o_dbg_state
);

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_duty_q;
  logic              r_period_start;
  logic [NUM_CH-1:0] r_out;

  logic [NUM_CH-1:0] w_en_out;
  logic [NUM_CH-1:0] w_en_pwm;
  logic              w_pwm_any;
  logic              w_enter;
  logic              w_exit;
  logic              w_run;
  logic              w_tick;
  logic              w_boundary;
  logic              w_duty_full;
  logic [NUM_CH-1:0] w_pwm_sig;
  logic [NUM_CH-1:0] w_out_next;

  assign w_en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign w_pwm_any = |w_en_pwm;

  assign w_enter = (r_state == ST_IDLE) &&  w_pwm_any;
  assign w_exit  = (r_state == ST_RUN)  && !w_pwm_any;
  // The divider is stopped on the exit cycle as well, so an exit that lands
  // on a boundary tick cannot also advance the counter or load the duty.
  assign w_run   = (r_state == ST_RUN)  &&  w_pwm_any;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .tick  (w_tick)
  );

  assign w_boundary = w_tick && (r_cnt == {CNT_W{1'b1}});

  // FSM, period counter and duty shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_duty_q       <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= 1'b0;
      if (w_enter) begin
        r_state        <= ST_RUN;
        r_cnt          <= '0;
        r_duty_q       <= pwm_duty_cycle;
        r_period_start <= 1'b1;
      end else if (w_exit) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else if (w_tick) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_boundary) begin
          // A duty written in the same cycle as the boundary is taken here
          // and governs the period that is just starting.
          r_duty_q       <= pwm_duty_cycle;
          r_period_start <= 1'b1;
        end
      end
    end
  end

  assign w_duty_full = (r_duty_q == DUTY_FULL);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] w_phase;
`ifdef PWM_STAGGER_EN
    assign w_phase = r_cnt + stagger_offset(g);
`else
    assign w_phase = r_cnt;
`endif
    // 0xFF must be a true 100 %: cnt < 0xFF would leave one low count.
    assign w_pwm_sig[g]  = w_duty_full || (w_phase < r_duty_q);
    assign w_out_next[g] = w_en_out[g] ? (w_en_pwm[g] ? w_pwm_sig[g] : 1'b1)
                                       : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_out_next;
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pwm_output_driver.sv
// ---------------------------------------------------------------------------
// tb_pwm_output_driver
//   Two instances share all inputs: u_dut runs with CLK_DIV=1 (one count per
//   clk) and u_dut_div3 with CLK_DIV=3 to exercise the prescaler.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   A "window" is the span from one period_start pulse up to (not including)
//   the next; within it the bench counts cycles with out[0] high and cycles
//   with any output high. Because out is registered from the counter, the
//   first sample of a window reflects the last count of the previous period
//   (or, on RUN entry, count 0 compared against the duty held before entry).
// ---------------------------------------------------------------------------
module tb_pwm_output_driver;

  logic        clk;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out1, out3;
  logic        ps1, ps3;
  logic [0:0]  st1, st3;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pwm_output_driver #(.CLK_DIV(1)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out1),
    .period_start    (ps1),
    .o_dbg_state     (st1)
  );

  pwm_output_driver #(.CLK_DIV(3)) u_dut_div3 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out3),
    .period_start    (ps3),
    .o_dbg_state     (st3)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    eo_lo = eo[7:0];
    eo_hi = eo[15:8];
    ep_lo = ep[7:0];
    ep_hi = ep[15:8];
    duty  = d;
  endtask

  // Measures one u_dut window. At window offset change_at the duty input is
  // rewritten to nd (pass -1 for no change).
  task automatic measure1(input int change_at, input logic [7:0] nd,
                          output int hi, output int nz, output int len);
    int w;
    w = 0;
    while (!ps1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!ps1) check("ps1_timeout", 32'(ps1), 32'd1);
    hi = 0; nz = 0; len = 0;
    do begin
      hi += int'(out1[0]);
      nz += (out1 != 16'h0) ? 1 : 0;
      if (len == change_at) duty = nd;
      len++;
      @(negedge clk);
    end while (!ps1 && len < 600);
  endtask

  task automatic run_window(input string tag, input int change_at, input logic [7:0] nd,
                            input int exp_hi, input int exp_nz);
    int hi, nz, len;
    exp_q.push_back(32'(exp_hi));
    exp_q.push_back(32'(exp_nz));
    exp_q.push_back(32'd256);
    measure1(change_at, nd, hi, nz, len);
    sb_check({tag, "_hi"}, 32'(hi));
    sb_check({tag, "_nz"}, 32'(nz));
    sb_check({tag, "_len"}, 32'(len));
  endtask

  task automatic run_window_div3(input string tag, input int exp_hi, input int exp_len);
    int w, hi, len;
    exp_q.push_back(32'(exp_hi));
    exp_q.push_back(32'(exp_len));
    w = 0;
    while (!ps3 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!ps3) check("ps3_timeout", 32'(ps3), 32'd1);
    hi = 0; len = 0;
    do begin
      hi += int'(out3[0]);
      len++;
      @(negedge clk);
    end while (!ps3 && len < 2000);
    sb_check({tag, "_hi"}, 32'(hi));
    sb_check({tag, "_len"}, 32'(len));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    rst_n = 1'b0;
    set_cfg(16'h0000, 16'h0000, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out1), 32'h0);
    check("rst_ps", 32'(ps1), 32'h0);
    check("rst_state", 32'(st1), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: static outputs, FSM stays IDLE, no period_start.
    set_cfg(16'hFFFF, 16'h0000, 8'(32'($urandom_range(0, 255))));
    exp_q.push_back(32'hFFFF);
    @(negedge clk);
    sb_check("t1_out", 32'(out1));
    exp_q.push_back(32'd0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (ps1 || st1 != 1'b0 || out1 != 16'hFFFF) bad++;
    end
    sb_check("t1_idle_cycles_bad", 32'(bad));

    // 2: 50 % on channel 0. Entry window: out at the first sample still
    // compares against the reset duty 0, so it is low there as well.
    set_cfg(16'h0001, 16'h0001, 8'h80);
    exp_q.push_back(32'd1);
    @(negedge clk);
    sb_check("t2_entry_ps", 32'(ps1));
    run_window("t2_w0", -1, 8'h00, 128, 128);
    run_window("t2_w1", -1, 8'h00, 128, 128);
    run_window_div3("t2_div3", 384, 768);

    // 3: duty 0x00 then 0xFF; each write lands at the next boundary.
    run_window("t3_sync", -1, 8'h00, 128, 128);
    duty = 8'h00;
    run_window("t3_cur", -1, 8'h00, 128, 128);
    for (int i = 0; i < 3; i++) run_window($sformatf("t3_zero%0d", i), -1, 8'h00, 0, 0);
    duty = 8'hFF;
    run_window("t3_cur_ff", -1, 8'h00, 0, 0);
    // First 0xFF window: its first sample came from count 255 at duty 0.
    run_window("t3_ff_first", -1, 8'h00, 255, 255);
    for (int i = 0; i < 3; i++) run_window($sformatf("t3_full%0d", i), -1, 8'h00, 256, 256);

    // 4: 0x40 then a mid-period change to 0xC0 at count 100.
    duty = 8'h40;
    run_window("t4_cur_ff", -1, 8'h00, 256, 256);
    // First sample is count 255 under 0xFF (high) plus 64 counts.
    run_window("t4_first40", -1, 8'h00, 65, 65);
    run_window("t4_mid_change", 100, 8'hC0, 64, 64);
    run_window("t4_c0", -1, 8'h00, 192, 192);
    // Duty written on the boundary cycle itself applies to the next period.
    run_window("t4_bnd_write", 255, 8'h20, 192, 192);
    run_window("t4_20", -1, 8'h00, 32, 32);

    // RUN->IDLE exactly on a boundary tick: exit wins, no period_start.
    repeat (255) @(negedge clk);
    set_cfg(16'h0001, 16'h0000, 8'h20);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h0001);
    @(negedge clk);
    sb_check("bnd_exit_ps", 32'(ps1));
    sb_check("bnd_exit_state", 32'(st1));
    sb_check("bnd_exit_static_out", 32'(out1));
    set_cfg(16'h0001, 16'h0001, 8'h80);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    @(negedge clk);
    sb_check("reentry_ps", 32'(ps1));
    sb_check("reentry_state", 32'(st1));
    // Counter restarted at 0; first sample is count 0 against held duty 0x20.
    run_window("reentry_w", -1, 8'h00, 129, 129);

    // 5: en_out=0 overrides PWM on every channel.
    set_cfg(16'h0000, 16'hFFFF, 8'h80);
    @(negedge clk);
    run_window("t5_masked", -1, 8'h00, 0, 0);
    set_cfg(16'h0000, 16'h0000, 8'h80);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    @(negedge clk);
    sb_check("t5_exit_state", 32'(st1));
    sb_check("t5_exit_ps", 32'(ps1));
    set_cfg(16'h0001, 16'h0001, 8'h80);
    @(negedge clk);
    run_window("t5_restart", -1, 8'h00, 129, 129);

    // 6: asynchronous reset mid-period.
    set_cfg(16'h0001, 16'h0001, 8'hFF);
    repeat (50) @(negedge clk);
    exp_q.push_back(32'h0001);
    sb_check("t6_pre_rst_out", 32'(out1));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    sb_check("t6_async_out", 32'(out1));
    sb_check("t6_async_ps", 32'(ps1));
    sb_check("t6_async_state", 32'(st1));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    @(negedge clk);
    sb_check("t6_first_ps", 32'(ps1));
    sb_check("t6_state_run", 32'(st1));
    // First sample compares count 0 against the reset duty 0.
    run_window("t6_after_rst", -1, 8'h00, 255, 255);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
